// File: rtl/serial_link_apb_cfg_regs.sv
// APB completer for the serial link CTRL and ISOLATED registers.
// Adds programmable wait states and a clock-gating isolation interlock.
module serial_link_apb_cfg_regs #(
  parameter int          AddrWidth  = 32,
  parameter int          WaitCycles = 1,
  parameter logic [31:0] CtrlRstVal = 32'h300
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic                 pready_o,
  output logic [31:0]          prdata_o,
  output logic                 pslverr_o,
  output logic                 clk_ena_o,
  output logic                 link_rst_no,
  output logic                 axi_in_isolate_o,
  output logic                 axi_out_isolate_o,
  input  logic [1:0]           isolated_i
);

  localparam int CntW =
    (WaitCycles < 2) ? 1 : $clog2(WaitCycles + 1);
  localparam logic [CntW-1:0] CntLoad =
    CntW'((WaitCycles > 0) ? WaitCycles - 1 : 0);
  localparam logic [3:0] CtrlRst =
    {CtrlRstVal[9:8], CtrlRstVal[1:0]};

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    RESP
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_write;
  logic            r_bad;
  logic [1:0]      r_off;
  logic [3:0]      r_wdata;
  logic [1:0]      r_strb;
  // Only the four implemented bits {9,8,1,0} are stored.
  logic [3:0]      r_ctrl;

  logic            w_resp;
  logic            w_addr_bad;
  logic            w_is_ctrl;
  logic            w_is_iso;
  logic [3:0]      w_ctrl_nxt;
  logic            w_lock_err;
  logic            w_commit;
  logic            w_unused;

  assign w_unused = ^{pwdata_i[31:10], pwdata_i[7:2],
                      paddr_i[1:0], pstrb_i[3:2]};

  if (AddrWidth > 4) begin : g_upper
    assign w_addr_bad = |paddr_i[AddrWidth-1:4];
  end else begin : g_no_upper
    assign w_addr_bad = 1'b0;
  end

  assign w_resp    = (r_state == RESP);
  assign w_is_ctrl = !r_bad && (r_off == 2'd0);
  assign w_is_iso  = !r_bad && (r_off == 2'd1);

  assign w_ctrl_nxt[3:2] =
    r_strb[1] ? r_wdata[3:2] : r_ctrl[3:2];
  assign w_ctrl_nxt[1:0] =
    r_strb[0] ? r_wdata[1:0] : r_ctrl[1:0];

  // Gating the clock needs both ports isolated and acknowledged.
  assign w_lock_err = r_ctrl[0] && !w_ctrl_nxt[0] &&
                      (!w_ctrl_nxt[2] || !w_ctrl_nxt[3] ||
                       (isolated_i != 2'b11));

  assign w_commit = w_resp && r_write && w_is_ctrl &&
                    !w_lock_err;

  assign pready_o = w_resp;

  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    if (w_resp) begin
      unique case (1'b1)
        w_is_ctrl: begin
          pslverr_o = r_write && w_lock_err;
          if (!r_write)
            prdata_o = {22'b0, r_ctrl[3:2],
                        6'b0, r_ctrl[1:0]};
        end
        w_is_iso: begin
          pslverr_o = r_write;
          if (!r_write)
            prdata_o = {30'b0, isolated_i};
        end
        default: pslverr_o = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_bad   <= 1'b0;
      r_off   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_ctrl  <= CtrlRst;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            r_state <= SETUP;
            r_write <= pwrite_i;
            r_bad   <= w_addr_bad;
            r_off   <= paddr_i[3:2];
            r_wdata <= {pwdata_i[9:8], pwdata_i[1:0]};
            r_strb  <= {pstrb_i[1], pstrb_i[0]};
          end
        end
        SETUP: begin
          if (!psel_i) begin
            r_state <= IDLE;
          end else if (penable_i) begin
            if (WaitCycles > 0) begin
              r_state <= WAIT;
              r_cnt   <= CntLoad;
            end else begin
              r_state <= RESP;
            end
          end
        end
        WAIT: begin
          if (!psel_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          if (w_commit)
            r_ctrl <= w_ctrl_nxt;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign clk_ena_o         = r_ctrl[0];
  assign link_rst_no       = r_ctrl[1];
  assign axi_in_isolate_o  = r_ctrl[2];
  assign axi_out_isolate_o = r_ctrl[3];

endmodule

// File: tb/tb_serial_link_apb_cfg_regs.sv
// Directed bench for serial_link_apb_cfg_regs.
// WaitCycles=1: every access completes 2 cycles after penable.
module tb_serial_link_apb_cfg_regs;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        clk_ena;
  logic        link_rst_n;
  logic        iso_in;
  logic        iso_out;
  logic [1:0]  isolated;

  int n_chk;
  int n_fail;

  serial_link_apb_cfg_regs #(
    .AddrWidth (32),
    .WaitCycles(1),
    .CtrlRstVal(32'h300)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .paddr_i          (paddr),
    .psel_i           (psel),
    .penable_i        (penable),
    .pwrite_i         (pwrite),
    .pwdata_i         (pwdata),
    .pstrb_i          (pstrb),
    .pready_o         (pready),
    .prdata_o         (prdata),
    .pslverr_o        (pslverr),
    .clk_ena_o        (clk_ena),
    .link_rst_no      (link_rst_n),
    .axi_in_isolate_o (iso_in),
    .axi_out_isolate_o(iso_out),
    .isolated_i       (isolated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Nibble order matches CTRL bits {9,8,1,0}.
  task automatic chk_outs(input string tag,
                          input logic [3:0] exp);
    chk(tag, {28'b0, iso_out, iso_in, link_rst_n, clk_ena},
        {28'b0, exp});
  endtask

  task automatic xfer(input  logic [31:0] a,
                      input  logic        w,
                      input  logic [31:0] d,
                      input  logic [3:0]  s,
                      output logic [31:0] rd,
                      output logic        er,
                      output int          lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    while (lat < 20 && !pready) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("pready", {31'b0, pready}, 32'd1);
    rd = prdata;
    er = pslverr;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("pready_pulse", {31'b0, pready}, 32'd0);
  endtask

  task automatic wr(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  s,
                    input logic        exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(a, 1'b1, d, s, rd, er, lat);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_lat"}, lat, 32'd2);
  endtask

  task automatic rdchk(input string tag,
                       input logic [31:0] a,
                       input logic [31:0] exp,
                       input logic        exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(a, 1'b0, 32'h0, 4'h0, rd, er, lat);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_lat"}, lat, 32'd2);
  endtask

  task automatic start_to_wait(input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    paddr = 32'h0; pwrite = 1'b1;
    pwdata = d; pstrb = 4'hf;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("wait_pready", {31'b0, pready}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0;
    pstrb = '0; isolated = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("rst_outs", 4'b1100);
    chk("rst_pready", {31'b0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    rst = 1'b0;

    rdchk("rst_ctrl", 32'h0, 32'h300, 1'b0);

    // Stray penable without setup is ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_pready", {31'b0, pready}, 32'd0);
    end
    psel = 1'b0; penable = 1'b0;

    wr("up0", 32'h0, 32'h302, 4'hf, 1'b0);
    chk_outs("up0_outs", 4'b1110);
    wr("up1", 32'h0, 32'h303, 4'hf, 1'b0);
    chk_outs("up1_outs", 4'b1111);
    wr("up2", 32'h0, 32'h003, 4'hf, 1'b0);
    chk_outs("up2_outs", 4'b0011);
    rdchk("up_ctrl", 32'h0, 32'h003, 1'b0);
    rdchk("iso00", 32'h4, 32'h0, 1'b0);

    wr("lock", 32'h0, 32'h000, 4'hf, 1'b1);
    chk_outs("lock_outs", 4'b0011);
    rdchk("lock_ctrl", 32'h0, 32'h003, 1'b0);
    wr("reiso", 32'h0, 32'h303, 4'hf, 1'b0);
    isolated = 2'b11;
    wr("gate", 32'h0, 32'h302, 4'hf, 1'b0);
    chk_outs("gate_outs", 4'b1110);

    wr("s_init", 32'h0, 32'h300, 4'hf, 1'b0);
    wr("s0", 32'h0, 32'h003, 4'b0001, 1'b0);
    rdchk("s0_ctrl", 32'h0, 32'h303, 1'b0);
    wr("s1", 32'h0, 32'h000, 4'b0010, 1'b0);
    rdchk("s1_ctrl", 32'h0, 32'h003, 1'b0);
    wr("s_none", 32'h0, 32'h300, 4'b0000, 1'b0);
    rdchk("snone_ctrl", 32'h0, 32'h003, 1'b0);

    wr("e_iso_wr", 32'h4, 32'hffff_ffff, 4'hf, 1'b1);
    rdchk("e_off8", 32'h8, 32'h0, 1'b1);
    rdchk("e_upper", 32'h1000_0000, 32'h0, 1'b1);
    wr("e_upper_wr", 32'h1000_0000, 32'h300, 4'hf, 1'b1);
    rdchk("e_ctrl", 32'h0, 32'h003, 1'b0);
    rdchk("iso11", 32'h4, 32'h3, 1'b0);

    wr("ab_init", 32'h0, 32'h303, 4'hf, 1'b0);
    start_to_wait(32'h003);
    psel = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_pready", {31'b0, pready}, 32'd0);
    end
    chk_outs("abort_outs", 4'b1111);
    rdchk("abort_ctrl", 32'h0, 32'h303, 1'b0);

    start_to_wait(32'h000);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("mid_rst_outs", 4'b1100);
    chk("mid_rst_pready", {31'b0, pready}, 32'd0);
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_err", {31'b0, pslverr}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rdchk("post_rst_ctrl", 32'h0, 32'h300, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
